// File: rtl/constraint_sample_ctrl.sv
// constraint_sample_ctrl
// Rejection-sampling controller. A 64-bit Galois LFSR produces candidate
// vectors for an external combinational constraint datapath. Candidates whose
// enforced constraint bits all pass are delivered on a valid/ready stream.
// A run ends when the requested sample count has been delivered (done pulse)
// or when one sample uses up its attempt budget (sticky fail).
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start, req_count begin a run of req_count samples (honoured in IDLE only)
//   seed_load, seed  reload the LFSR in IDLE (seed 0 loads 64'h1)
//   cons_mask        constraints to enforce (1 = enforced)
//   cand_vec         candidate to the datapath (low VEC_W bits of the LFSR)
//   cons_res         datapath result bits for cand_vec, same cycle
//   sample_valid/ready/data  accepted-sample stream
//   busy, done, fail status; tries_cnt rejected attempts for current sample
//   total_attempts   EVAL cycles since reset, saturating
//
// state | meaning
// IDLE  | waiting for start; seed may be loaded
// GEN   | step the LFSR to produce a new candidate
// EVAL  | judge the candidate against the enabled constraints
// HOLD  | accepted sample presented, waiting for the consumer
module constraint_sample_ctrl #(
    parameter int unsigned VEC_W     = 62,
    parameter int unsigned N_CONS    = 8,
    parameter int unsigned MAX_TRIES = 1024,
    parameter logic [63:0] SEED      = 64'h1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       req_count,
    input  logic              seed_load,
    input  logic [63:0]       seed,
    input  logic [N_CONS-1:0] cons_mask,
    output logic [VEC_W-1:0]  cand_vec,
    input  logic [N_CONS-1:0] cons_res,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic [VEC_W-1:0]  sample_data,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [15:0]       tries_cnt,
    output logic [31:0]       total_attempts
);

    localparam logic [63:0] POLY     = 64'hD800_0000_0000_0000;
    localparam logic [15:0] LAST_TRY = 16'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        EVAL = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [63:0]        lfsr_q, lfsr_d;
    logic               valid_q, valid_d;
    logic [VEC_W-1:0]   data_q, data_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;
    logic [15:0]        tries_q, tries_d;
    logic [31:0]        total_q, total_d;
    logic [15:0]        remaining_q, remaining_d;
    logic               pass;

    // A constraint that is masked off counts as satisfied.
    assign pass = &(cons_res | ~cons_mask);

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        valid_d     = valid_q;
        data_d      = data_q;
        done_d      = 1'b0;
        fail_d      = fail_q;
        tries_d     = tries_q;
        total_d     = total_q;
        remaining_d = remaining_q;

        case (state_q)
            IDLE: begin
                // Seed load happens first so a simultaneous start steps from the new seed.
                if (seed_load) begin
                    lfsr_d = (seed == 64'h0) ? 64'h1 : seed;
                end
                if (start) begin
                    fail_d = 1'b0;
                    if (req_count == 16'h0) begin
                        done_d = 1'b1;
                    end else begin
                        remaining_d = req_count;
                        tries_d     = 16'h0;
                        state_d     = GEN;
                    end
                end
            end
            GEN: begin
                lfsr_d  = {1'b0, lfsr_q[63:1]} ^ (lfsr_q[0] ? POLY : 64'h0);
                state_d = EVAL;
            end
            EVAL: begin
                if (total_q != 32'hFFFF_FFFF) begin
                    total_d = total_q + 32'd1;
                end
                if (pass) begin
                    data_d  = cand_vec;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else if (tries_q == LAST_TRY) begin
                    fail_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tries_d = tries_q + 16'd1;
                    state_d = GEN;
                end
            end
            HOLD: begin
                // valid is always high here, so ready alone completes the handshake.
                if (sample_ready) begin
                    valid_d     = 1'b0;
                    remaining_d = remaining_q - 16'd1;
                    tries_d     = 16'h0;
                    if (remaining_q == 16'd1) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = GEN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            valid_q     <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            tries_q     <= 16'h0;
            total_q     <= 32'h0;
            remaining_q <= 16'h0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            tries_q     <= tries_d;
            total_q     <= total_d;
            remaining_q <= remaining_d;
        end
    end

    assign cand_vec       = lfsr_q[VEC_W-1:0];
    assign sample_valid   = valid_q;
    assign sample_data    = data_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign fail           = fail_q;
    assign tries_cnt      = tries_q;
    assign total_attempts = total_q;

endmodule

// File: tb/tb_constraint_sample_ctrl.sv
module tb_constraint_sample_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] req_count;
    logic        seed_load;
    logic [63:0] seed;
    logic [7:0]  cons_mask;
    logic        sample_ready;
    logic        use_func;
    logic [7:0]  res_fix;
    logic [7:0]  res_b;

    logic [61:0] cand_a, data_a, cand_b, data_b;
    logic [7:0]  cons_res_a;
    logic        valid_a, busy_a, done_a, fail_a;
    logic        valid_b, busy_b, done_b, fail_b;
    logic [15:0] tries_a, tries_b;
    logic [31:0] total_a, total_b;

    int checks;
    int failures;

    function automatic logic [7:0] cons_func(input logic [61:0] c);
        return c[7:0] ^ c[23:16] ^ c[47:40];
    endfunction

    assign cons_res_a = use_func ? cons_func(cand_a) : res_fix;

    constraint_sample_ctrl #(.VEC_W(62), .N_CONS(8), .MAX_TRIES(1024), .SEED(64'h1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .req_count(req_count),
        .seed_load(seed_load), .seed(seed), .cons_mask(cons_mask),
        .cand_vec(cand_a), .cons_res(cons_res_a), .sample_valid(valid_a),
        .sample_ready(sample_ready), .sample_data(data_a), .busy(busy_a),
        .done(done_a), .fail(fail_a), .tries_cnt(tries_a), .total_attempts(total_a)
    );

    constraint_sample_ctrl #(.VEC_W(62), .N_CONS(8), .MAX_TRIES(4), .SEED(64'h1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .req_count(req_count),
        .seed_load(seed_load), .seed(seed), .cons_mask(cons_mask),
        .cand_vec(cand_b), .cons_res(res_b), .sample_valid(valid_b),
        .sample_ready(sample_ready), .sample_data(data_b), .busy(busy_b),
        .done(done_b), .fail(fail_b), .tries_cnt(tries_b), .total_attempts(total_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR step written directly from the polynomial description.
    function automatic logic [63:0] step(input logic [63:0] x);
        return (x >> 1) ^ (x[0] ? 64'hD800_0000_0000_0000 : 64'h0);
    endfunction

    function automatic logic [63:0] stepn(input logic [63:0] x, input int n);
        logic [63:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = step(y);
        return y;
    endfunction

    function automatic logic passes(input logic [7:0] res, input logic [7:0] mask);
        return ((res | ~mask) == 8'hFF);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic nedge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; seed_load = 1'b0; seed = 64'h0;
        req_count = 16'h0; cons_mask = 8'h00; sample_ready = 1'b0;
        use_func = 1'b0; res_fix = 8'h00; res_b = 8'h00;
        nedge(); nedge();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [15:0] req;
        logic [7:0]  mask;
        logic [7:0]  res;
        int          exp_end;
        int          exp_done;
        logic        exp_fail;
        int          attempts;
    } row_t;

    row_t rows[6];

    initial begin
        int n;
        int done_cyc;
        logic busy_seen;
        logic [31:0] exp_total;
        logic [61:0] held_data, held_cand;
        logic done_seen;

        checks = 0; failures = 0;

        // req, mask, res, cycle busy drops, cycle of done, fail, EVAL count
        rows[0] = '{16'd0, 8'h00, 8'h00,    1,  1, 1'b0,    0};
        rows[1] = '{16'd3, 8'h00, 8'h00,   10, 10, 1'b0,    3};
        rows[2] = '{16'd1, 8'hFF, 8'hFF,    4,  4, 1'b0,    1};
        rows[3] = '{16'd2, 8'h0F, 8'h0F,    7,  7, 1'b0,    2};
        rows[4] = '{16'd1, 8'h01, 8'hFE, 2049,  0, 1'b1, 1024};
        rows[5] = '{16'd1, 8'h80, 8'h80,    4,  4, 1'b0,    1};

        // ---------------- reset state ----------------
        do_reset();
        check("rst_valid", valid_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_fail", fail_a, 0);
        check("rst_tries", tries_a, 0);
        check("rst_total", total_a, 0);
        check("rst_data", data_a, 0);
        check("rst_cand", cand_a, 62'h1);

        // ---------------- table-driven runs ----------------
        exp_total = 0;
        sample_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            cons_mask = rows[r].mask; res_fix = rows[r].res; req_count = rows[r].req;
            start = 1'b1;
            n = 0; done_cyc = 0; busy_seen = 1'b0;
            do begin
                nedge(); n++; start = 1'b0;
                if (busy_a) busy_seen = 1'b1;
                if (done_a && done_cyc == 0) done_cyc = n;
            end while (busy_a && n < 3000);
            exp_total += 32'(rows[r].attempts);
            check($sformatf("row%0d_end_cycle", r), 64'(n), 64'(rows[r].exp_end));
            check($sformatf("row%0d_done_cycle", r), 64'(done_cyc), 64'(rows[r].exp_done));
            check($sformatf("row%0d_fail", r), fail_a, rows[r].exp_fail);
            check($sformatf("row%0d_total", r), total_a, exp_total);
            check($sformatf("row%0d_busy_seen", r), busy_seen, rows[r].req != 0);
        end

        // ---------------- zero seed + three samples, exact timing ----------------
        do_reset();
        seed_load = 1'b1; seed = 64'h0; start = 1'b1; req_count = 16'd3;
        cons_mask = 8'h00; sample_ready = 1'b1;
        nedge(); start = 1'b0; seed_load = 1'b0;
        for (n = 1; n <= 10; n++) begin
            if (n == 3 || n == 6 || n == 9) begin
                check($sformatf("seq_valid_T%0d", n), valid_a, 1);
                check($sformatf("seq_data_T%0d", n), data_a, stepn(64'h1, n / 3) & 64'h3FFF_FFFF_FFFF_FFFF);
            end
            if (n == 5) check("seq_valid_low_T5", valid_a, 0);
            if (n == 9) check("seq_no_done_T9", done_a, 0);
            if (n == 10) begin
                check("seq_done_T10", done_a, 1);
                check("seq_busy_T10", busy_a, 0);
                check("seq_tries", tries_a, 0);
                check("seq_total", total_a, 3);
            end
            if (n < 10) nedge();
        end

        // ---------------- four rejections then accept ----------------
        do_reset();
        cons_mask = 8'hFF; res_fix = 8'h00; req_count = 16'd1; sample_ready = 1'b1;
        start = 1'b1;
        nedge(); start = 1'b0;
        for (n = 1; n <= 11; n++) begin
            if (n == 10) check("rej_tries", tries_a, 4);
            if (n == 10) check("rej_no_valid_T10", valid_a, 0);
            if (n == 11) begin
                check("rej_valid_T11", valid_a, 1);
                check("rej_data", data_a, stepn(64'h1, 5) & 64'h3FFF_FFFF_FFFF_FFFF);
                check("rej_total", total_a, 5);
            end
            res_fix = (n >= 9) ? 8'hFF : 8'h00;
            nedge();
        end

        // ---------------- attempt budget exhaustion (MAX_TRIES=4) ----------------
        do_reset();
        cons_mask = 8'h01; res_b = 8'h00; req_count = 16'd1; sample_ready = 1'b1;
        start = 1'b1;
        nedge(); start = 1'b0;
        done_seen = 1'b0;
        for (n = 1; n <= 9; n++) begin
            if (done_b) done_seen = 1'b1;
            if (n == 8) check("budget_fail_T8", fail_b, 0);
            if (n == 9) begin
                check("budget_fail_T9", fail_b, 1);
                check("budget_busy_T9", busy_b, 0);
                check("budget_tries", tries_b, 3);
                check("budget_total", total_b, 4);
            end
            if (n < 9) nedge();
        end
        check("budget_no_done", done_seen, 0);
        req_count = 16'd0; start = 1'b1;
        nedge(); start = 1'b0;
        check("budget_fail_cleared", fail_b, 0);
        check("budget_restart_done", done_b, 1);

        // ---------------- stall in HOLD, start while busy ----------------
        do_reset();
        cons_mask = 8'h00; req_count = 16'd2; sample_ready = 1'b0;
        start = 1'b1;
        nedge(); start = 1'b0;
        held_data = '0; held_cand = '0;
        for (n = 1; n <= 12; n++) begin
            if (n == 3) begin
                held_data = data_a; held_cand = cand_a;
                check("hold_valid", valid_a, 1);
                check("hold_data", data_a, stepn(64'h1, 1) & 64'h3FFF_FFFF_FFFF_FFFF);
            end
            if (n >= 4 && n <= 7) begin
                check($sformatf("hold_stable_data_%0d", n), data_a, held_data);
                check($sformatf("hold_stable_valid_%0d", n), valid_a, 1);
                check($sformatf("hold_lfsr_%0d", n), cand_a, held_cand);
            end
            if (n == 8) sample_ready = 1'b1;
            if (n == 9) begin
                check("hold_valid_dropped", valid_a, 0);
                sample_ready = 1'b0;
                start = 1'b1; req_count = 16'd5;
            end
            if (n == 10) start = 1'b0;
            if (n == 11) begin
                check("hold_second_data", data_a, stepn(64'h1, 2) & 64'h3FFF_FFFF_FFFF_FFFF);
                check("hold_second_valid", valid_a, 1);
                sample_ready = 1'b1;
            end
            if (n == 12) begin
                check("busy_start_ignored_done", done_a, 1);
                check("busy_start_ignored_idle", busy_a, 0);
            end
            if (n < 12) nedge();
        end

        // ---------------- reset in HOLD ----------------
        do_reset();
        cons_mask = 8'h00; req_count = 16'd1; sample_ready = 1'b0;
        start = 1'b1;
        nedge(); start = 1'b0;
        nedge(); nedge();
        check("rstmid_valid_before", valid_a, 1);
        rst = 1'b1;
        nedge();
        rst = 1'b0;
        check("rstmid_valid", valid_a, 0);
        check("rstmid_busy", busy_a, 0);
        check("rstmid_lfsr", cand_a, 62'h1);
        check("rstmid_total", total_a, 0);
        check("rstmid_data", data_a, 0);

        // ---------------- randomized runs vs transaction model ----------------
        do_reset();
        use_func = 1'b1;
        exp_total = 0;
        for (int run = 0; run < 10; run++) begin
            logic [63:0] sd, x;
            logic [61:0] q[$];
            logic [61:0] c;
            logic [7:0]  mask;
            int          req, s, tries, b1, b2;
            logic        mfail, done_obs;

            sd = {$urandom, $urandom};
            if (run == 2) sd = 64'h0;
            b1 = $urandom_range(0, 7);
            b2 = (b1 + $urandom_range(1, 7)) % 8;
            mask = 8'h00;
            mask[b1] = 1'b1;
            mask[b2] = 1'b1;
            req = $urandom_range(1, 6);

            x = (sd == 64'h0) ? 64'h1 : sd;
            q.delete(); s = 0; tries = 0; mfail = 1'b0;
            while (s < req && !mfail) begin
                x = step(x);
                c = x[61:0];
                if (exp_total != 32'hFFFF_FFFF) exp_total++;
                if (passes(cons_func(c), mask)) begin
                    q.push_back(c); s++; tries = 0;
                end else if (tries == 1023) begin
                    mfail = 1'b1;
                end else begin
                    tries++;
                end
            end

            cons_mask = mask; req_count = 16'(req);
            seed_load = 1'b1; seed = sd; start = 1'b1; sample_ready = 1'b0;
            nedge(); n = 1;
            start = 1'b0; seed_load = 1'b0;
            done_obs = 1'b0;
            while (busy_a && n < 20000) begin
                sample_ready = ($urandom_range(0, 3) != 0);
                if (valid_a && sample_ready) begin
                    if (q.size() == 0) check($sformatf("rand%0d_extra_sample", run), 1, 0);
                    else check($sformatf("rand%0d_data", run), data_a, q.pop_front());
                end
                nedge(); n++;
            end
            done_obs = done_a;
            sample_ready = 1'b0;
            check($sformatf("rand%0d_timeout", run), 64'(n < 20000), 1);
            check($sformatf("rand%0d_left", run), 64'(q.size()), 0);
            check($sformatf("rand%0d_done", run), done_obs, !mfail);
            check($sformatf("rand%0d_fail", run), fail_a, mfail);
            check($sformatf("rand%0d_total", run), total_a, exp_total);
            nedge();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
